pmp_check_ctrl: RTL

PMP_CHECK_CTRL -- requirements
Module: pmp_check_ctrl

---
 rtl/pmp_pkg.sv | 31 +++
 rtl/pmp_prio_enc.sv | 23 ++
 rtl/pmp_check_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pmp_pkg.sv
// Shared PMP definitions: address-match modes, cfg bit positions, request
// type encoding and the check controller FSM states.
package pmp_pkg;

  // A field modes
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_TOR   = 2'd1;
  localparam logic [1:0] MODE_NA4   = 2'd2;
  localparam logic [1:0] MODE_NAPOT = 2'd3;

  // cfg byte bit positions; bits 6:5 always read as zero
  localparam int unsigned CFG_R    = 0;
  localparam int unsigned CFG_W    = 1;
  localparam int unsigned CFG_X    = 2;
  localparam int unsigned CFG_A_LO = 3;
  localparam int unsigned CFG_A_HI = 4;
  localparam int unsigned CFG_L    = 7;

  // Request access types
  localparam logic [1:0] REQ_R    = 2'b00;
  localparam logic [1:0] REQ_W    = 2'b01;
  localparam logic [1:0] REQ_X    = 2'b10;
  localparam logic [1:0] REQ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StResp  = 2'd2
  } pmp_state_e;

endpackage

// File: rtl/pmp_prio_enc.sv
// Lowest-index priority encoder: reports whether any bit of the valid vector
// is set and the index of the lowest set bit (0 when none).
module pmp_prio_enc #(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic [NUM_ENTRIES-1:0] i_valid,
  output logic                   o_hit,
  output logic [3:0]             o_idx
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    o_hit = 1'b0;
    o_idx = 4'd0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_hit = 1'b1;
        o_idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/pmp_check_ctrl.sv
// PMP check controller: holds the per-entry cfg/addr CSRs, exports them to an
// external address matcher, sequences IDLE -> CHECK -> RESP and resolves the
// permission fault for each request.
// Optional feature: define PMP_ERR_CAPTURE_EN to add first-fault address capture.
module pmp_check_ctrl
  import pmp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_csr_we,
  input  logic                        i_csr_sel,
  input  logic [3:0]                  i_csr_idx,
  input  logic [31:0]                 i_csr_wdata,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic [33:0]                 i_req_addr,
  input  logic [1:0]                  i_req_size,
  input  logic [1:0]                  i_req_type,
  input  logic                        i_req_priv_m,
  output logic [33:0]                 o_chk_addr,
  output logic [1:0]                  o_chk_size,
  output logic [NUM_ENTRIES-1:0][31:0] o_ent_addr,
  output logic [NUM_ENTRIES-1:0][31:0] o_ent_pre_addr,
  output logic [NUM_ENTRIES-1:0][1:0]  o_ent_mode,
  input  logic [NUM_ENTRIES-1:0]      i_match,
`ifdef PMP_ERR_CAPTURE_EN
  input  logic                        i_err_clr,
  output logic                        o_err_valid,
  output logic [33:0]                 o_err_addr,
`endif
  output logic                        o_resp_valid,
  input  logic                        i_resp_ready,
  output logic                        o_resp_fault,
  output logic                        o_resp_hit,
  output logic [3:0]                  o_resp_idx
);

  logic [NUM_ENTRIES-1:0][7:0]  r_cfg;
  logic [NUM_ENTRIES-1:0][31:0] r_addr;
  logic [NUM_ENTRIES-1:0]       w_cfg_we;
  logic [NUM_ENTRIES-1:0]       w_addr_we;
  logic [NUM_ENTRIES-1:0]       w_active;
  logic [7:0]                   w_cfg_wdata;

  pmp_state_e r_state, w_state_next;
  logic [33:0] r_req_addr;
  logic [1:0]  r_req_size;
  logic [1:0]  r_req_type;
  logic        r_req_priv_m;

  logic        w_hit;
  logic [3:0]  w_hit_idx;
  logic [7:0]  w_hit_cfg;
  logic        w_perm;
  logic        w_fault;

  // Zero the reserved bits and drop W when R is clear (W without R is illegal)
  assign w_cfg_wdata = {i_csr_wdata[7], 2'b00, i_csr_wdata[4:2],
                        i_csr_wdata[1] & i_csr_wdata[0], i_csr_wdata[0]};

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    logic w_sel;
    logic w_tor_lock;
    // Writes to an index with no entry simply never select anything
    assign w_sel = i_csr_we && (i_csr_idx == 4'(g));
    if (g + 1 < NUM_ENTRIES) begin : g_next
      assign w_tor_lock = r_cfg[g+1][CFG_L] && (r_cfg[g+1][CFG_A_HI:CFG_A_LO] == MODE_TOR);
    end else begin : g_last
      assign w_tor_lock = 1'b0;
    end
    assign w_cfg_we[g]  = w_sel && !i_csr_sel && !r_cfg[g][CFG_L];
    assign w_addr_we[g] = w_sel && i_csr_sel && !r_cfg[g][CFG_L] && !w_tor_lock;
    assign w_active[g]  = i_match[g] && (r_cfg[g][CFG_A_HI:CFG_A_LO] != MODE_OFF);
    assign o_ent_addr[g] = r_addr[g];
    assign o_ent_mode[g] = r_cfg[g][CFG_A_HI:CFG_A_LO];
    if (g == 0) begin : g_pre0
      assign o_ent_pre_addr[g] = 32'd0;
    end else begin : g_pre
      assign o_ent_pre_addr[g] = r_addr[g-1];
    end
  end

  // CSR storage; a write during CHECK lands on the same edge the response is taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg  <= '0;
      r_addr <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (w_cfg_we[i])  r_cfg[i]  <= w_cfg_wdata;
        if (w_addr_we[i]) r_addr[i] <= i_csr_wdata;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_req_valid) w_state_next = StCheck;
      StCheck: w_state_next = StResp;
      StResp:  if (i_resp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs; the matcher only sees the request while checking
  always_comb begin
    o_req_ready  = (r_state == StIdle);
    o_resp_valid = (r_state == StResp);
    o_chk_addr   = (r_state == StCheck) ? r_req_addr : 34'd0;
    o_chk_size   = (r_state == StCheck) ? r_req_size : 2'd0;
  end

  // Latch the request on acceptance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_addr   <= '0;
      r_req_size   <= '0;
      r_req_type   <= '0;
      r_req_priv_m <= 1'b0;
    end else if (r_state == StIdle && i_req_valid) begin
      r_req_addr   <= i_req_addr;
      r_req_size   <= i_req_size;
      r_req_type   <= i_req_type;
      r_req_priv_m <= i_req_priv_m;
    end
  end

  pmp_prio_enc #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_prio_enc (
    .i_valid (w_active),
    .o_hit   (w_hit),
    .o_idx   (w_hit_idx)
  );

  // Fault resolution for the winning entry (or the no-hit default)
  always_comb begin
    w_hit_cfg = 8'd0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (w_hit_idx == 4'(i)) w_hit_cfg = r_cfg[i];
    end
    unique case (r_req_type)
      REQ_R:   w_perm = w_hit_cfg[CFG_R];
      REQ_W:   w_perm = w_hit_cfg[CFG_W];
      REQ_X:   w_perm = w_hit_cfg[CFG_X];
      default: w_perm = 1'b0;
    endcase
    if (r_req_type == REQ_RSVD)                 w_fault = 1'b1;
    else if (!w_hit)                            w_fault = !r_req_priv_m;
    else if (r_req_priv_m && !w_hit_cfg[CFG_L]) w_fault = 1'b0;
    else                                        w_fault = !w_perm;
  end

  // Response register, captured at the end of CHECK and held through RESP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_resp_fault <= 1'b0;
      o_resp_hit   <= 1'b0;
      o_resp_idx   <= 4'd0;
    end else if (r_state == StCheck) begin
      o_resp_fault <= w_fault;
      o_resp_hit   <= w_hit;
      o_resp_idx   <= w_hit_idx;
    end
  end

`ifdef PMP_ERR_CAPTURE_EN
  // First-fault capture; clear has priority over a coincident fault
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_valid <= 1'b0;
      o_err_addr  <= '0;
    end else if (i_err_clr) begin
      o_err_valid <= 1'b0;
    end else if (r_state == StCheck && w_fault && !o_err_valid) begin
      o_err_valid <= 1'b1;
      o_err_addr  <= r_req_addr;
    end
  end
`endif

endmodule
